// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register.
// Mode codes, FSM states and the per-edge step function.
package shift_pkg;

  localparam int unsigned MAX_W = 64;

  typedef logic [MAX_W-1:0] word_t;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_SHR  = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_ROR  = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;
  localparam logic [2:0] MODE_LOAD = 3'd5;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_e;

  function automatic logic is_shift(
    input logic [2:0] m
  );
    return (m == MODE_SHR) || (m == MODE_SHL) ||
           (m == MODE_ROR) || (m == MODE_ROL);
  endfunction

  // q and ld must be zero above bit w-1; result keeps that property.
  function automatic word_t step_fn(
    input logic [2:0]  m,
    input word_t       q,
    input word_t       ld,
    input int unsigned w,
    input logic        sr,
    input logic        sl
  );
    word_t mask;
    word_t msb;
    word_t r;
    mask = (word_t'(1) << w) - word_t'(1);
    msb  = (q >> (w - 1)) & word_t'(1);
    r    = q;
    case (m)
      MODE_SHR:  r = (q >> 1) | (word_t'(sr) << (w - 1));
      MODE_SHL:  r = ((q << 1) | word_t'(sl)) & mask;
      MODE_ROR:  r = (q >> 1) | (word_t'(q[0]) << (w - 1));
      MODE_ROL:  r = ((q << 1) | msb) & mask;
      MODE_LOAD: r = ld & mask;
      default:   r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shift_univ.sv
// Universal shift register with single-step ops and
// an auto-burst mode reporting busy and done.
module shift_univ
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  input  logic             start,
  input  logic [CNT_W-1:0] shift_count,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_r,
  output logic             ser_out_l,
  output logic             busy,
  output logic             done
);

  localparam int unsigned W = WIDTH;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mlat_q, mlat_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             done_q, done_d;

  logic [2:0]       op;
  word_t            nxt;

  always_comb begin
    op = (state_q == ST_BURST) ? mlat_q : mode;
    nxt = step_fn(op, word_t'(q_q), word_t'(load_data),
                  W, ser_in_r, ser_in_l);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mlat_d  = mlat_q;
    q_d     = q_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && is_shift(mode)) begin
          // Zero-length burst completes immediately.
          if (shift_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_BURST;
            cnt_d   = shift_count;
            mlat_d  = mode;
          end
        end else begin
          q_d = nxt[WIDTH-1:0];
        end
      end
      ST_BURST: begin
        q_d   = nxt[WIDTH-1:0];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mlat_q  <= MODE_HOLD;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mlat_q  <= mlat_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

  assign q         = q_q;
  assign ser_out_r = q_q[0];
  assign ser_out_l = q_q[WIDTH-1];
  assign busy      = (state_q == ST_BURST);
  assign done      = done_q;

endmodule

// File: tb/tb_shift_univ.sv
// Directed scoreboard bench for shift_univ (WIDTH=4, CNT_W=3).
module tb_shift_univ;

  logic       clock = 1'b0;
  logic       clear;
  logic [2:0] mode;
  logic [3:0] load_data;
  logic       ser_in_r;
  logic       ser_in_l;
  logic       start;
  logic [2:0] shift_count;
  logic [3:0] q;
  logic       ser_out_r;
  logic       ser_out_l;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic       sr;
    logic       sl;
  } obs_t;

  obs_t  sb_q[$];
  string tag_q[$];

  always #5 clock = ~clock;

  shift_univ #(.WIDTH(4), .CNT_W(3)) dut (
    .clock(clock),
    .clear(clear),
    .mode(mode),
    .load_data(load_data),
    .ser_in_r(ser_in_r),
    .ser_in_l(ser_in_l),
    .start(start),
    .shift_count(shift_count),
    .q(q),
    .ser_out_r(ser_out_r),
    .ser_out_l(ser_out_l),
    .busy(busy),
    .done(done)
  );

  task automatic cyc(
    input string      tag,
    input logic [3:0] eq,
    input logic       eb,
    input logic       ed
  );
    obs_t e;
    obs_t o;
    string t;
    e = '{q: eq, busy: eb, done: ed, sr: eq[0], sl: eq[3]};
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    o = '{q: q, busy: busy, done: done,
          sr: ser_out_r, sl: ser_out_l};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: q/busy/done/sr/sl got %b %b %b %b %b expected %b %b %b %b %b",
             t, o.q, o.busy, o.done, o.sr, o.sl,
             e.q, e.busy, e.done, e.sr, e.sl);
    end
  endtask

  initial begin
    clear = 1'b1; mode = 3'd5; load_data = 4'b1010;
    ser_in_r = 1'b1; ser_in_l = 1'b1;
    start = 1'b1; shift_count = 3'd3;
    cyc("reset", 4'b0000, 1'b0, 1'b0);
    mode = 3'd1;
    cyc("clear_over_start", 4'b0000, 1'b0, 1'b0);
    clear = 1'b0; start = 1'b0; mode = 3'd0;
    cyc("no_burst_after_clear", 4'b0000, 1'b0, 1'b0);

    mode = 3'd5; load_data = 4'b1011;
    cyc("load_1011", 4'b1011, 1'b0, 1'b0);
    mode = 3'd1; ser_in_r = 1'b0;
    cyc("shr1", 4'b0101, 1'b0, 1'b0);
    cyc("shr2", 4'b0010, 1'b0, 1'b0);
    cyc("shr3", 4'b0001, 1'b0, 1'b0);
    cyc("shr4", 4'b0000, 1'b0, 1'b0);
    mode = 3'd2; ser_in_l = 1'b1;
    cyc("shl_in1", 4'b0001, 1'b0, 1'b0);
    mode = 3'd1; ser_in_r = 1'b1;
    cyc("shr_in1", 4'b1000, 1'b0, 1'b0);
    mode = 3'd6;
    cyc("reserved_hold", 4'b1000, 1'b0, 1'b0);

    mode = 3'd4; start = 1'b1; shift_count = 3'd3;
    cyc("rol_start", 4'b1000, 1'b1, 1'b0);
    mode = 3'd0; start = 1'b0;
    cyc("rol_s1", 4'b0001, 1'b1, 1'b0);
    cyc("rol_s2", 4'b0010, 1'b1, 1'b0);
    cyc("rol_s3_done", 4'b0100, 1'b0, 1'b1);
    cyc("rol_after", 4'b0100, 1'b0, 1'b0);

    mode = 3'd5; load_data = 4'b0110;
    cyc("load_0110", 4'b0110, 1'b0, 1'b0);
    mode = 3'd3; start = 1'b1; shift_count = 3'd7;
    cyc("ror_start", 4'b0110, 1'b1, 1'b0);
    mode = 3'd5; load_data = 4'b1111; shift_count = 3'd1;
    cyc("ror_s1", 4'b0011, 1'b1, 1'b0);
    cyc("ror_s2", 4'b1001, 1'b1, 1'b0);
    cyc("ror_s3", 4'b1100, 1'b1, 1'b0);
    cyc("ror_s4", 4'b0110, 1'b1, 1'b0);
    cyc("ror_s5", 4'b0011, 1'b1, 1'b0);
    cyc("ror_s6", 4'b1001, 1'b1, 1'b0);
    cyc("ror_s7_done", 4'b1100, 1'b0, 1'b1);

    mode = 3'd2; start = 1'b1; shift_count = 3'd0;
    cyc("shl_cnt0_done", 4'b1100, 1'b0, 1'b1);
    mode = 3'd5; load_data = 4'b0101;
    cyc("start_load", 4'b0101, 1'b0, 1'b0);
    mode = 3'd0; start = 1'b0;
    cyc("hold_no_done", 4'b0101, 1'b0, 1'b0);

    mode = 3'd1; start = 1'b1; shift_count = 3'd5;
    ser_in_r = 1'b1;
    cyc("shr5_start", 4'b0101, 1'b1, 1'b0);
    start = 1'b0;
    cyc("shr5_s1", 4'b1010, 1'b1, 1'b0);
    ser_in_r = 1'b0;
    cyc("shr5_s2", 4'b0101, 1'b1, 1'b0);
    clear = 1'b1;
    cyc("clear_in_burst", 4'b0000, 1'b0, 1'b0);
    clear = 1'b0; mode = 3'd0;
    cyc("no_done_after_clear", 4'b0000, 1'b0, 1'b0);

    mode = 3'd2; start = 1'b1; shift_count = 3'd2;
    ser_in_l = 1'b1;
    cyc("shl2_start", 4'b0000, 1'b1, 1'b0);
    mode = 3'd0; start = 1'b0;
    cyc("shl2_s1", 4'b0001, 1'b1, 1'b0);
    cyc("shl2_s2_done", 4'b0011, 1'b0, 1'b1);
    cyc("shl2_after", 4'b0011, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
